// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// serial_fa_cell
// One-bit full adder built from two half-add stages and an OR for carry.
// Purely combinational; the controller time-multiplexes a single instance.
// Ports:
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit
//   c    : carry out
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic c
);

  logic p;
  logic g1;
  logic g2;

  // first half add: operands
  assign p  = x ^ y;
  assign g1 = x & y;

  // second half add: propagate with carry in
  assign s  = p ^ cin;
  assign g2 = p & cin;

  assign c  = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller. Accepts one operand pair through a
// valid/ready handshake, adds it LSB-first over WIDTH clock cycles using a
// single full-add cell, then holds sum/cout until the consumer takes them.
// Optional macro SERIAL_ADD_SUB_EN adds the sub port and the subtract path
// (B inverted, carry-in 1, cout acts as a no-borrow flag).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start_valid : operand pair valid (IDLE only)
//   start_ready : high in IDLE
//   sub         : subtract select (only with SERIAL_ADD_SUB_EN)
//   a, b        : operands, sampled on the accept edge
//   busy        : high in RUN
//   done_valid  : result valid, high in DONE
//   done_ready  : consumer takes the result (DONE only)
//   sum, cout   : registered result and carry-out
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             sub_sel;
  logic             accept;
  logic             last;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign accept = start_valid && (state == IDLE);
  assign last   = (cnt == LAST);

  serial_fa_cell u_fa (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result
  // has walked down to bit 0. Written this way so it also holds for WIDTH=1.
  assign psum_nxt = WIDTH'({fa_s, psum} >> 1);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and status outputs (decoded from state only)
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: load on accept, one bit per RUN edge, publish on last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      // subtract as a + ~b + 1: inverted B with the +1 as carry-in
      b_sh  <= sub_sel ? ~b : b;
      carry <= sub_sel;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      psum  <= psum_nxt;
      carry <= fa_c;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= psum_nxt;
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl at WIDTH=8: vector table of operand
// pairs with hand-computed results, plus sequences for back-pressure,
// asynchronous reset mid-RUN and back-to-back issue.
// Define SERIAL_ADD_SUB_EN to also exercise the subtract path.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub_in;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
`ifdef SERIAL_ADD_SUB_EN
    .sub         (sub_in),
`endif
    .a           (a_in),
    .b           (b_in),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
    int           hold;
    string        nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, RUN with garbage on the inputs, optional
  // back-pressure hold, then consume.
  task automatic do_op(input vec_t v);
    int w;
    int lat;
    w = 0;
    while (!start_ready && w < 50) begin
      tick;
      w++;
    end
    chk({v.nm, " start_ready"}, 32'(start_ready), 32'd1);
    a_in = v.a;
    b_in = v.b;
`ifdef SERIAL_ADD_SUB_EN
    sub_in = v.s;
`endif
    start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    chk({v.nm, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done_valid && lat < 50) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      sub_in = 1'($urandom);
`endif
      tick;
      lat++;
    end
    chk({v.nm, " latency"}, 32'(lat), 32'(W));
    chk({v.nm, " sum"}, 32'(sum), 32'(v.es));
    chk({v.nm, " cout"}, 32'(cout), 32'(v.ec));
    for (int i = 0; i < v.hold; i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      start_valid = 1'b1;
      tick;
      start_valid = 1'b0;
      chk({v.nm, " hold sum"}, 32'(sum), 32'(v.es));
      chk({v.nm, " hold cout"}, 32'(cout), 32'(v.ec));
      chk({v.nm, " hold done_valid"}, 32'(done_valid), 32'd1);
      chk({v.nm, " hold start_ready"}, 32'(start_ready), 32'd0);
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    chk({v.nm, " consumed"}, 32'(done_valid), 32'd0);
    chk({v.nm, " ready again"}, 32'(start_ready), 32'd1);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    logic [W:0]   ref_res;
    logic [W:0]   pend;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    int           last_acc;
    int           nres;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, "5a+3c"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "ff+01"};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, "00+00"};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, "80+80"};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 5, "a5+5a hold"};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, "7f+01"};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0, "ff+ff"};

    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a_in = '0;
    b_in = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub_in = 1'b0;
`endif

    // reset state
    repeat (2) tick;
    chk("reset start_ready", 32'(start_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done_valid", 32'(done_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

`ifdef SERIAL_ADD_SUB_EN
    v = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0, "10-01"};
    do_op(v);
    v = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0, "01-02"};
    do_op(v);
    v = '{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 0, "33-33"};
    do_op(v);
`endif

    // reset at RUN cycle 4 while an older nonzero sum is held
    a_in = 8'h77;
    b_in = 8'h11;
    start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    repeat (3) tick;
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst start_ready", 32'(start_ready), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst done_valid", 32'(done_valid), 32'd0);
    chk("async rst sum", 32'(sum), 32'd0);
    chk("async rst cout", 32'(cout), 32'd0);
    #1 rst = 1'b0;
    tick;
    v = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "12+34 after rst"};
    do_op(v);

    // back-to-back with done_ready tied high
`ifdef SERIAL_ADD_SUB_EN
    sub_in = 1'b0;
`endif
    done_ready = 1'b1;
    start_valid = 1'b1;
    a_in = W'($urandom);
    b_in = W'($urandom);
    last_acc = -1;
    nres = 0;
    pend = '0;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      na = a_in;
      nb = b_in;
      if (done_valid) begin
        chk("b2b sum", 32'(sum), 32'(pend[W-1:0]));
        chk("b2b cout", 32'(cout), 32'(pend[W]));
        nres++;
      end
      if (start_ready) begin
        if (last_acc >= 0) chk("b2b interval", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        ref_res = {1'b0, na} + {1'b0, nb};
        pend = ref_res;
      end
      tick;
      if (last_acc == cyc) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
    end
    chk("b2b result count", 32'(nres), 32'd4);
    start_valid = 1'b0;
    done_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
